// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity encodings, oversampling and
// the tick divisor calculation used by the receiver and the baud generator.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  // Clock cycles per oversampling tick, integer-truncated.
  function automatic int clks_per_tick(input int sys_clk_freq, input int baud_rate);
    return sys_clk_freq / (baud_rate * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: a reloading down-counter that emits a
// one-cycle tick at terminal count. restart reloads it so the next tick
// lands a full period later, aligning the tick grid to an external event.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count down, reload on terminal count or restart.
  always_comb begin
    cnt_d = cnt_q;
    if (restart || (cnt_q == '0)) cnt_d = RELOAD;
    else                          cnt_d = cnt_q - 1'b1;
  end

  assign tick = (cnt_q == '0) && !restart;

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= RELOAD;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, 16x oversampled frame FSM with parity
// and stop checking, and a one-entry output register with a read handshake.
//
// state     | meaning
// ----------|---------------------------------------------------------
// ST_IDLE   | waiting for an armed falling edge on rx_s
// ST_START  | counting to mid start bit, rejecting glitches
// ST_DATA   | sampling DATA_BITS data bits, LSB first
// ST_PARITY | sampling the parity bit
// ST_STOP   | sampling the stop bit, then committing the frame
// ST_BREAK  | stop bit was low; waiting for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 100_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CLKS_PER_TICK = clks_per_tick(SYS_CLK_FREQ, BAUD_RATE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic                 sync1_q, rx_s_q, rx_prev_q;
  logic [1:0]           fill_q, fill_d;
  logic                 armed_q, armed_d;
  uart_state_e          state_q, state_d;
  logic [3:0]           os_cnt_q, os_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic tick, restart, falling, commit, stop_bad;

  uart_baud_tick #(.DIV(CLKS_PER_TICK)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // The synchroniser flops come out of reset high, so rx_s only reflects the
  // real line once fill_q[1] is set; arming waits for that to avoid treating
  // the reset value as a genuine idle-high sample.
  assign falling = armed_q && rx_prev_q && !rx_s_q;

  // Frame FSM: sample-point counting, data shift and parity evaluation.
  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    fill_d    = {fill_q[0], 1'b1};
    armed_d   = armed_q | (fill_q[1] & rx_s_q);
    restart   = 1'b0;
    commit    = 1'b0;
    stop_bad  = 1'b0;

    // The 4-bit sample counter wraps 0 -> 15, giving 16 ticks per bit after
    // the initial 8-tick half-bit in START.
    if (tick && (state_q != ST_IDLE) && (state_q != ST_BREAK))
      os_cnt_d = os_cnt_q - 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (falling) begin
          restart   = 1'b1;
          os_cnt_d  = 4'd7;
          par_err_d = 1'b0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (tick && (os_cnt_q == 4'd0)) begin
          bit_cnt_d = BW'(DATA_BITS - 1);
          state_d   = rx_s_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick && (os_cnt_q == 4'd0)) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == '0)
            state_d = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
          else
            bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      ST_PARITY: begin
        if (tick && (os_cnt_q == 4'd0)) begin
          par_err_d = (^{shift_q, rx_s_q}) ^ (PARITY_MODE == PARITY_ODD);
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick && (os_cnt_q == 4'd0)) begin
          commit   = 1'b1;
          stop_bad = !rx_s_q;
          state_d  = rx_s_q ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register: load on commit when free or being read, else flag overrun.
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    if (commit) begin
      if (!rx_valid_q || rd_en) begin
        rx_data_d    = shift_q;
        parity_err_d = par_err_q;
        frame_err_d  = stop_bad;
        rx_valid_d   = 1'b1;
        overrun_d    = 1'b0;
      end else begin
        overrun_d    = 1'b1;
      end
    end else if (rd_en && rx_valid_q) begin
      rx_valid_d   = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  // All state registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      fill_q       <= 2'b00;
      armed_q      <= 1'b0;
      state_q      <= ST_IDLE;
      os_cnt_q     <= 4'd0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= rx;
      rx_s_q       <= sync1_q;
      rx_prev_q    <= rx_s_q;
      fill_q       <= fill_d;
      armed_q      <= armed_d;
      state_q      <= state_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
